// File: rtl/sysbus.sv
// sysbus: shared line-memory bus arbiter for HART_CNT harts.
// Serialises level-held line read/write requests with round-robin arbitration,
// runs one memory transaction at a time, returns data plus a one-cycle h_dv
// pulse, and broadcasts an invalidate to all other harts after each write.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   h_addr/h_rd/h_wr       per-hart request address and level request bits
//   h_data_out             per-hart write data
//   h_data_in, h_dv        broadcast read data, per-hart completion pulse
//   inv_addr, inv          broadcast invalidate address, per-hart invalidate pulse
//   m_addr/m_rd/m_wr       memory request
//   m_data_out/m_data_in   memory write/read data
//   m_dv                   memory completion
module sysbus #(
  parameter int unsigned HART_CNT = 2,
  parameter int unsigned LINE     = 512,
  parameter int unsigned OFFS     = $clog2(LINE / 8)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [HART_CNT*64-1:0]   h_addr,
  input  logic [HART_CNT-1:0]      h_rd,
  input  logic [HART_CNT-1:0]      h_wr,
  input  logic [HART_CNT*LINE-1:0] h_data_out,
  output logic [LINE-1:0]          h_data_in,
  output logic [HART_CNT-1:0]      h_dv,
  output logic [63:0]              inv_addr,
  output logic [HART_CNT-1:0]      inv,
  output logic [63:0]              m_addr,
  output logic                     m_rd,
  output logic                     m_wr,
  output logic [LINE-1:0]          m_data_out,
  input  logic [LINE-1:0]          m_data_in,
  input  logic                     m_dv
);

  localparam int unsigned IdxW = (HART_CNT > 1) ? $clog2(HART_CNT) : 1;
  localparam logic [63:0] AddrMask = ~((64'd1 << OFFS) - 64'd1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;      // also the grant index while BUSY/RESP
  logic              wr_q, wr_d;
  logic              mask_q;              // previous cycle was RESP
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       inv_addr_q, inv_addr_d;
  logic [LINE-1:0]   wdata_q, wdata_d;
  logic [LINE-1:0]   rdata_q, rdata_d;

  logic [HART_CNT-1:0] req;
  logic [HART_CNT-1:0] grant_oh;
  logic                win_vld;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand_idx;
  int unsigned         cand;
  logic                sel_wr;
  logic [63:0]         sel_addr;
  logic [LINE-1:0]     sel_data;

  assign req = h_rd | h_wr;

  // Round-robin search from last+1; the hart just served is skipped for one
  // cycle so its still-high request level is not mistaken for a new request.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= HART_CNT; k++) begin
      cand     = (int'(last_q) + k) % HART_CNT;
      cand_idx = IdxW'(cand);
      if (!win_vld && req[cand_idx] && !(mask_q && (cand_idx == last_q))) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Mux the winner's request; a simultaneous rd+wr is served as a write first.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(HART_CNT); i++) begin
      if (IdxW'(i) == win_idx) begin
        sel_wr   = h_wr[i];
        sel_addr = h_addr[64*i +: 64];
        sel_data = h_data_out[LINE*i +: LINE];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(HART_CNT - 1);
      wr_q       <= 1'b0;
      mask_q     <= 1'b0;
      addr_q     <= '0;
      inv_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      mask_q     <= (state_q == StResp);
      addr_q     <= addr_d;
      inv_addr_q <= inv_addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    inv_addr_d = inv_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StBusy;
          last_d  = win_idx;
          wr_d    = sel_wr;
          addr_d  = sel_addr & AddrMask;
          wdata_d = sel_data;
        end
      end
      StBusy: begin
        if (m_dv) begin
          state_d = StResp;
          if (wr_q) inv_addr_d = addr_q;
          else      rdata_d    = m_data_in;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs, decoded from state and latched transaction
  always_comb begin
    for (int i = 0; i < int'(HART_CNT); i++) begin
      grant_oh[i] = (IdxW'(i) == last_q);
    end
    m_rd = (state_q == StBusy) && !wr_q;
    m_wr = (state_q == StBusy) && wr_q;
    h_dv = (state_q == StResp) ? grant_oh : '0;
    inv  = ((state_q == StResp) && wr_q) ? ~grant_oh : '0;
  end

  assign m_addr     = addr_q;
  assign m_data_out = wdata_q;
  assign h_data_in  = rdata_q;
  assign inv_addr   = inv_addr_q;

endmodule

// File: tb/tb_sysbus.sv
module tb_sysbus;
  localparam int unsigned HC = 4;
  localparam int unsigned LW = 512;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [HC*64-1:0] h_addr = '0;
  logic [HC-1:0]    h_rd = '0;
  logic [HC-1:0]    h_wr = '0;
  logic [HC*LW-1:0] h_data_out = '0;
  logic [LW-1:0]    h_data_in;
  logic [HC-1:0]    h_dv;
  logic [63:0]      inv_addr;
  logic [HC-1:0]    inv;
  logic [63:0]      m_addr;
  logic             m_rd;
  logic             m_wr;
  logic [LW-1:0]    m_data_out;
  logic [LW-1:0]    m_data_in = '0;
  logic             m_dv = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  sysbus #(.HART_CNT(HC), .LINE(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_addr     (h_addr),
    .h_rd       (h_rd),
    .h_wr       (h_wr),
    .h_data_out (h_data_out),
    .h_data_in  (h_data_in),
    .h_dv       (h_dv),
    .inv_addr   (inv_addr),
    .inv        (inv),
    .m_addr     (m_addr),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_dv       (m_dv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: wait (bounded) for a request, answer next cycle, and
  // report the address, op and the h_dv seen in the response cycle.
  task automatic serve(output logic [63:0] addr, output logic wr, output logic [HC-1:0] dv);
    bit found = 1'b0;
    addr = '0;
    wr   = 1'b0;
    dv   = '0;
    for (int c = 0; c < 20; c++) begin
      if (m_rd || m_wr) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_vec++;
    assert (found) else begin
      n_fail++;
      $error("FAIL serve_timeout: observed no m_rd/m_wr, expected a request within 20 cycles");
    end
    if (found) begin
      addr      = m_addr;
      wr        = m_wr;
      m_data_in = {8{addr}};
      m_dv      = 1'b1;
      step();
      dv   = h_dv;
      m_dv = 1'b0;
    end
  endtask

  logic [63:0]   a;
  logic          w;
  logic [HC-1:0] d;
  logic [63:0]   rr_exp [5];

  initial begin
    // Reset outputs
    #12;
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_h_dv", h_dv, 0);
    chk("rst_inv", inv, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_inv_addr", inv_addr, 0);
    chk("rst_h_data_in", h_data_in, 0);
    chk("rst_m_data_out", m_data_out, 0);

    // First read from hart 0, offset bits cleared
    step();
    rst_n          = 1'b1;
    h_addr[63:0]   = 64'h1038;
    h_rd[0]        = 1'b1;
    step();
    chk("h0_m_rd", m_rd, 1);
    chk("h0_m_addr", m_addr, 64'h1000);
    m_dv      = 1'b1;
    m_data_in = {64{8'h3C}};
    step();
    chk("h0_h_dv", h_dv, 4'b0001);
    chk("h0_data", h_data_in, {64{8'h3C}});
    m_dv    = 1'b0;
    h_rd[0] = 1'b0;
    step();
    chk("h0_dv_pulse", h_dv, 0);

    // Read return for hart 1 with 4-cycle memory latency
    h_addr[127:64] = 64'h3000;
    h_rd[1]        = 1'b1;
    step();
    chk("h1_m_rd", m_rd, 1);
    chk("h1_m_addr", m_addr, 64'h3000);
    step();
    step();
    step();
    chk("h1_m_rd_held", m_rd, 1);
    chk("h1_no_dv_yet", h_dv, 0);
    m_dv      = 1'b1;
    m_data_in = {64{8'hA5}};
    step();
    chk("h1_h_dv", h_dv, 4'b0010);
    chk("h1_data", h_data_in, {64{8'hA5}});
    chk("h1_inv", inv, 0);
    chk("h1_m_rd_low", m_rd, 0);
    m_dv      = 1'b0;
    m_data_in = '0;
    h_rd[1]   = 1'b0;
    step();
    chk("h1_dv_pulse", h_dv, 0);
    chk("h1_data_hold", h_data_in, {64{8'hA5}});

    // Write from hart 2 invalidates harts 0,1,3
    h_data_out[LW*0 +: LW] = {16{32'h0000_00F0}};
    h_data_out[LW*2 +: LW] = {16{32'hD2D2_0002}};
    h_addr[191:128]        = 64'h2040;
    h_wr[2]                = 1'b1;
    step();
    chk("h2_m_wr", m_wr, 1);
    chk("h2_m_rd", m_rd, 0);
    chk("h2_m_addr", m_addr, 64'h2040);
    chk("h2_m_data_out", m_data_out, {16{32'hD2D2_0002}});
    m_dv = 1'b1;
    step();
    chk("h2_h_dv", h_dv, 4'b0100);
    chk("h2_inv", inv, 4'b1011);
    chk("h2_inv_addr", inv_addr, 64'h2040);
    m_dv    = 1'b0;
    h_wr[2] = 1'b0;
    step();
    chk("h2_inv_pulse", inv, 0);
    chk("h2_inv_addr_hold", inv_addr, 64'h2040);

    // m_dv in IDLE is ignored
    m_dv = 1'b1;
    step();
    m_dv = 1'b0;
    chk("idle_mdv_h_dv", h_dv, 0);
    step();
    chk("idle_mdv_m_rd", m_rd, 0);

    // Round-robin after reset: all four harts hold reads
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    h_addr = {64'h40000, 64'h30000, 64'h20000, 64'h10000};
    h_rd   = 4'b1111;
    rr_exp = '{64'h10000, 64'h20000, 64'h30000, 64'h40000, 64'h10000};
    for (int t = 0; t < 5; t++) begin
      serve(a, w, d);
      chk($sformatf("rr_addr_%0d", t), a, rr_exp[t]);
      chk($sformatf("rr_rd_%0d", t), w, 0);
    end
    h_rd = '0;
    step();
    step();
    chk("rr_quiet", m_rd, 0);

    // Write-before-read on hart 1 (last grant was hart 0)
    h_addr[127:64] = 64'h4000;
    h_rd[1]        = 1'b1;
    h_wr[1]        = 1'b1;
    serve(a, w, d);
    chk("wbr_first_wr", w, 1);
    chk("wbr_first_dv", d, 4'b0010);
    h_wr[1] = 1'b0;
    serve(a, w, d);
    chk("wbr_second_wr", w, 0);
    chk("wbr_second_addr", a, 64'h4000);
    h_rd[1] = 1'b0;
    step();
    step();

    // Reset mid-transaction
    h_addr[255:192] = 64'h5000;
    h_rd[3]         = 1'b1;
    step();
    chk("mid_m_rd", m_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_m_rd", m_rd, 0);
    chk("mid_async_m_addr", m_addr, 0);
    step();
    chk("mid_no_dv", h_dv, 0);
    rst_n = 1'b1;
    serve(a, w, d);
    chk("mid_reserve_addr", a, 64'h5000);
    chk("mid_reserve_dv", d, 4'b1000);
    h_rd[3] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sysbus.md
# sysbus

Shared system bus arbiter between up to `HART_CNT` harts and the single off-chip line memory. It accepts line-granular read (refill) and write (writeback) requests on each hart's `h_*` port, serialises them with round-robin arbitration, runs one memory transaction at a time and returns data and completion to the requesting hart. On every completed write it sends an invalidate to all other harts to keep their L2 copies coherent.

## Interface
Parameters:
- `HART_CNT`, 2: number of hart ports, 1..8.
- `LINE`, `` `hmem_line ``: line width in bits, a power of two and at least 64.
- `OFFS`, log2(`LINE`/8): number of byte-offset bits cleared in line addresses.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `h_addr` in `HART_CNT`*64: per-hart request address. Hart i uses bits [64i+63:64i].
- `h_rd` in `HART_CNT`: per-hart line read request, level.
- `h_wr` in `HART_CNT`: per-hart line write request, level.
- `h_data_out` in `HART_CNT`*`LINE`: per-hart write data.
- `h_data_in` out `LINE`: read data, broadcast to all harts.
- `h_dv` out `HART_CNT`: per-hart completion pulse.
- `inv_addr` out 64: invalidate line address, broadcast to all harts.
- `inv` out `HART_CNT`: per-hart invalidate pulse.
- `m_addr` out 64: memory line address.
- `m_rd` out 1: memory read request.
- `m_wr` out 1: memory write request.
- `m_data_out` out `LINE`: memory write data.
- `m_data_in` in `LINE`: memory read data.
- `m_dv` in 1: memory completion. Qualifies `m_data_in` on a read and acknowledges a write.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- **Requests.** A request is level-held. The hart keeps `h_rd`/`h_wr`, `h_addr` and `h_data_out` stable until its `h_dv` pulse. If one hart asserts `h_rd` and `h_wr` together, the write is served first and the read stays pending.
- **IDLE.** If any request is eligible, choose a winner.
  - The search is round-robin, starting at `last+1` and wrapping from `HART_CNT-1` to 0.
  - On the clock edge, latch the grant index, the operation, the address with bits [`OFFS`-1:0] zeroed, and the write data. Set `last` to the grant index and go to BUSY.
  - With no eligible request, stay in IDLE.
- **BUSY.** Drive `m_addr` and `m_data_out` from the latch. Hold `m_rd` or `m_wr` at 1 until `m_dv` is sampled high.
  - On `m_dv`: for a read, latch `m_data_in` into `h_data_in`; then go to RESP.
  - `m_dv` is ignored in IDLE and RESP.
- **RESP.** Drive `h_dv[grant]`=1 for exactly one cycle, then return to IDLE.
  - For a write, also drive `inv[j]`=1 for every j ≠ grant and set `inv_addr` to the latched line address, in the same cycle.
  - For a read, `inv` stays all-zero.
- **Masking.** In the IDLE cycle immediately after RESP, the just-served hart's request is masked (not eligible). This prevents a stale level from re-granting the same hart.
- **Single hart.** With `HART_CNT`=1, `inv` is never asserted.
- **Reset.** Asserting `rst_n` low at any time, including mid-BUSY, immediately forces:
  - state to IDLE and `last` to `HART_CNT-1`, so hart 0 has first priority;
  - `m_rd`, `m_wr`, `h_dv` and `inv` to 0;
  - `m_addr`, `inv_addr`, `h_data_in` and `m_data_out` to 0.
  - The interrupted memory transaction is abandoned without a response.

## Timing
- All outputs are registered or decoded directly from state. There is no combinational path from any `h_*` input to any `m_*` output.
- Request seen in IDLE in cycle 0 gives `m_rd`/`m_wr` high from cycle 1.
- `m_dv` high in cycle k (k ≥ 1) gives `h_dv` (and `inv` for a write) in cycle k+1, and IDLE in cycle k+2.
- Minimum turnaround is 3 cycles per transaction, so peak throughput is one line every 3 cycles.
- `h_data_in` stays valid from the `h_dv` cycle until the next read's `m_dv` capture.
- `inv_addr` holds its value until the next write's RESP.
- Fairness: a continuously requesting hart is granted within `HART_CNT` transactions.

## Test plan
- **Reset outputs.** Drive `rst_n`=0 -> all outputs 0. Release reset, then hart 0 reads 0x1038 with `LINE`=512 -> `m_addr`=0x1000 and `m_rd`=1 in the next cycle.
- **Read return.** Hart 1 reads, memory answers `m_dv` 4 cycles after `m_rd` rises with `m_data_in`=0xA5.. pattern -> `h_dv`=2'b10 for one cycle the cycle after `m_dv`, `h_data_in` equals the pattern, `inv`=0.
- **Write invalidate.** `HART_CNT`=4, hart 2 writes 0x2040 -> `m_wr`=1 with `m_data_out` equal to hart 2's data. After `m_dv`: `h_dv`=4'b0100, `inv`=4'b1011, `inv_addr`=0x2040, all in the same single cycle.
- **Round-robin.** All 4 harts hold reads continuously -> grant order 0,1,2,3,0, and no hart is granted twice in a row.
- **Write before read.** One hart asserts `h_rd` and `h_wr` together -> `m_wr` transaction first, then `m_rd` transaction.
- **Reset mid-transaction.** Pull `rst_n` low during BUSY with `m_rd`=1 -> `m_rd` drops without waiting for a clock edge, and no `h_dv` is ever issued. After release, the request, still held, is re-served from scratch.
